mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
External memory bus controller directly upstream of the MAU. Accepts one byte-wide read or write request at a time and runs an asynchronous-SRAM-style bus cycle (setup, strobe with wait states, hold). Returns the MAU's `mem_res` completion pulse and `data_in` read byte. The MAU's `data_out` byte feeds `req_wdata`.

Parameters:
- ADDR_W, 16, width of request and bus address.
- WAIT_CYCLES, 2, minimum strobe cycles beyond the first (0 allowed).
- TIMEOUT_CYCLES, 255, ACCESS cycles with `bus_ready` low before abort; used only with the optional feature.

Ports:
- cpu_clk  in  1  clock, rising edge.
- cpu_rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present; held by requester until accepted.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  8  write byte (MAU `data_out`).
- req_ready  out  1  controller idle; request accepted when `req_valid && req_ready`.
- mem_res  out  1  one-cycle completion pulse to MAU.
- rd_data  out  8  read byte (MAU `data_in`).
- bus_err  out  1  pulses with `mem_res` on timeout abort.
- bus_addr  out  ADDR_W  bus address.
- bus_cs_n  out  1  chip select, active-low.
- bus_oe_n  out  1  output enable (read strobe), active-low.
- bus_we_n  out  1  write strobe, active-low.
- bus_wdata  out  8  write data.
- bus_wdata_en  out  1  write-data drive enable (external tristate).
- bus_rdata  in  8  read data from bus.
- bus_ready  in  1  device ready; low inserts extra wait states.

Behaviour:
- All outputs registered or decoded from state register only. No combinational path from inputs to outputs.
- Reset values:
  - `req_ready` = 1.
  - `mem_res`, `bus_err`, `bus_wdata_en` = 0.
  - `bus_cs_n`, `bus_oe_n`, `bus_we_n` = 1.
  - `bus_addr` = 0, `bus_wdata` = 0, `rd_data` = 8'h00.
  - state = IDLE.
- Reset mid-operation: the next edge forces IDLE and deasserts all strobes. The in-flight request is dropped with no `mem_res`.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch addr, we and wdata, then go to SETUP.
  - `req_valid` is sampled only in IDLE; in any other state it is ignored and `req_ready` = 0.
- SETUP (1 cycle):
  - `bus_cs_n` = 0, `bus_addr` valid, `bus_wdata_en` = `we`.
  - Load wait counter with WAIT_CYCLES, then go to ACCESS.
- ACCESS:
  - CS asserted; `bus_oe_n` = 0 for a read, `bus_we_n` = 0 for a write.
  - Counter decrements each cycle, saturating at 0.
  - Exit when counter == 0 and `bus_ready` == 1. On that edge a read captures `bus_rdata` into `rd_data`. Then go to HOLD.
  - Minimum ACCESS length is WAIT_CYCLES+1 cycles.
- HOLD (1 cycle):
  - Strobes deasserted; CS, addr, wdata and `wdata_en` held.
  - `mem_res` = 1 this cycle only, then go to IDLE.
- Latency: acceptance edge to `mem_res` high is WAIT_CYCLES+3 cycles with `bus_ready` = 1. Back-to-back requests have one IDLE cycle between HOLD and the next SETUP.
- `rd_data` is held until the next read completes; writes leave it unchanged.
- `bus_wdata_en` is never 1 during a read transaction. `bus_oe_n` and `bus_we_n` are never both 0.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in ACCESS while `bus_ready` == 0 and clears when `bus_ready` == 1.
  - On reaching TIMEOUT_CYCLES it forces HOLD. A read sets `rd_data` = 8'hFF.
  - `bus_err` = 1 together with `mem_res`.
- Undefined: no timeout counter; ACCESS waits indefinitely; `bus_err` tied 0.

Decomposition:
- Package `mem_bus_pkg`:
  - `bus_state_t` enum (IDLE, SETUP, ACCESS, HOLD).
  - `BUS_ERR_DATA` = 8'hFF.
  - `bus_req_t` packed struct (addr, we, wdata).
- Sub-module `wait_timer`: load/decrement counter with zero flag, parameterised width. Instanced for wait states and, when enabled, for timeout.

Test Plan:
- Read, WAIT_CYCLES=2, `bus_ready` = 1, addr 16'h1234, `bus_rdata` 8'hA5 -> `bus_oe_n` low for 3 cycles; `mem_res` high exactly 5 cycles after acceptance; `rd_data` = 8'hA5; `bus_we_n` and `bus_wdata_en` never asserted.
- Write 8'h3C to 16'h8001 -> `bus_we_n` low 3 cycles; `bus_wdata` = 8'h3C with `bus_wdata_en` from SETUP through HOLD; `mem_res` 1 cycle; `rd_data` unchanged.
- Read with `bus_ready` low 4 extra ACCESS cycles -> `mem_res` at cycle 9; no early capture of `bus_rdata`.
- Back-to-back write then read with `req_valid` held high -> `req_ready` low from acceptance through HOLD; second request accepted in the first IDLE cycle; both complete in order.
- `cpu_rst` asserted during ACCESS -> next edge: all strobes high, `req_ready` = 1, no `mem_res`, `rd_data` = 8'h00.
- MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, `bus_ready` stuck low on a read -> after 8 ACCESS cycles `mem_res` and `bus_err` pulse together; `rd_data` = 8'hFF.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_pkg
// Shared types and constants for the external memory bus controller
// (mem_bus_ctrl) and its wait_timer helper.
//   bus_state_t  : controller FSM states (IDLE, SETUP, ACCESS, HOLD)
//   bus_req_t    : latched request (addr, we, wdata)
//   BUS_ERR_DATA : read byte returned when an access is aborted on timeout
//   cnt_width()  : width needed for a down-counter loaded with a given value
// ---------------------------------------------------------------------------
package mem_bus_pkg;

  // Widest bus address the request struct can carry; mem_bus_ctrl ADDR_W
  // must not exceed this.
  localparam int BUS_ADDR_W = 16;

  // Read data substituted when a bus cycle is aborted by the timeout.
  localparam logic [7:0] BUS_ERR_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } bus_state_t;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic                  we;
    logic [7:0]            wdata;
  } bus_req_t;

  // Bits needed to hold values 0..max_val, never less than one bit so that
  // a zero load value still produces a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : mem_bus_pkg

// File: rtl/mem_bus_ctrl_wait_timer.sv
// ---------------------------------------------------------------------------
// wait_timer
// Loadable down-counter that saturates at zero and flags when it is empty.
// Used by mem_bus_ctrl for strobe wait states and, optionally, the
// bus_ready timeout.
//   clk_i      : clock, rising edge
//   srst_i     : synchronous active-high reset (count -> 0)
//   load_i     : load load_val_i this cycle (takes priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one, holding at zero
//   zero_o     : count is zero (decoded from the count register)
// ---------------------------------------------------------------------------
module wait_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule : wait_timer

// File: rtl/mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl
// Byte-wide external memory bus controller sitting directly upstream of the
// MAU. One request at a time is turned into an asynchronous-SRAM style bus
// cycle: SETUP (1 cycle) -> ACCESS (strobe, >= WAIT_CYCLES+1 cycles, extended
// while bus_ready is low) -> HOLD (1 cycle, mem_res pulse) -> IDLE.
//
// Optional feature (compile-time macro MEM_BUS_TIMEOUT_EN):
//   defined   : ACCESS is aborted after TIMEOUT_CYCLES consecutive cycles of
//               bus_ready low; reads return BUS_ERR_DATA and bus_err pulses
//               with mem_res.
//   undefined : ACCESS waits for bus_ready indefinitely; bus_err is tied 0.
//
// Ports
//   cpu_clk, cpu_rst : clock (rising edge), synchronous active-high reset
//   req_valid/req_ready : request handshake; accepted when both are high
//   req_we, req_addr, req_wdata : request direction, byte address, write byte
//   mem_res          : one-cycle completion pulse to the MAU
//   rd_data          : last completed read byte
//   bus_err          : completion was a timeout abort
//   bus_addr, bus_cs_n, bus_oe_n, bus_we_n : bus address and strobes
//   bus_wdata, bus_wdata_en : write data and its tristate drive enable
//   bus_rdata, bus_ready    : read data and device ready from the bus
//
// Every output is either a register or decoded from registers only, so no
// input reaches an output combinationally.
// ---------------------------------------------------------------------------
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int WAIT_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              req_ready,
  output logic              mem_res,
  output logic [7:0]        rd_data,
  output logic              bus_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_cs_n,
  output logic              bus_oe_n,
  output logic              bus_we_n,
  output logic [7:0]        bus_wdata,
  output logic              bus_wdata_en,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ready
);

  localparam int                WAIT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

  bus_state_t state_q;
  bus_state_t state_d;
  bus_req_t   req_q;
  bus_req_t   req_d;
  logic [7:0] rd_data_q;
  logic [7:0] rd_data_d;

  logic accept;
  logic wait_load;
  logic wait_dec;
  logic wait_zero;
  logic access_done;
  logic timeout_hit;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and per-state control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    wait_load   = 1'b0;
    wait_dec    = 1'b0;
    access_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        // req_valid is only looked at here; elsewhere it is ignored.
        if (req_valid) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        wait_load = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        wait_dec = 1'b1;
        // The wait counter enforces the minimum strobe width; bus_ready can
        // only stretch it. A timeout abort overrides both.
        if (timeout_hit || (wait_zero && bus_ready)) begin
          access_done = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Wait-state counter: loaded in SETUP, counts down through ACCESS.
  // -------------------------------------------------------------------------
  wait_timer #(
    .WIDTH (WAIT_W)
  ) u_wait_timer (
    .clk_i      (cpu_clk),
    .srst_i     (cpu_rst),
    .load_i     (wait_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (wait_dec),
    .zero_o     (wait_zero)
  );

  // -------------------------------------------------------------------------
  // Optional bus_ready timeout
  // -------------------------------------------------------------------------
`ifdef MEM_BUS_TIMEOUT_EN
  // The counter holds the number of further ready-low cycles tolerated, so
  // it is loaded with TIMEOUT_CYCLES-1 and the abort fires in the cycle it
  // reads zero with bus_ready still low: that is the TIMEOUT_CYCLES-th
  // consecutive ready-low ACCESS cycle.
  localparam int                TO_LOAD_VAL = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int                TO_W        = cnt_width(TO_LOAD_VAL);
  localparam logic [TO_W-1:0]   TO_LOAD     = TO_W'(TO_LOAD_VAL);

  logic to_load;
  logic to_dec;
  logic to_zero;
  logic err_q;
  logic err_d;

  // A ready-high cycle in ACCESS restarts the count.
  assign to_load = (state_q == SETUP) || ((state_q == ACCESS) && bus_ready);
  assign to_dec  = (state_q == ACCESS) && !bus_ready;

  wait_timer #(
    .WIDTH (TO_W)
  ) u_timeout_timer (
    .clk_i      (cpu_clk),
    .srst_i     (cpu_rst),
    .load_i     (to_load),
    .load_val_i (TO_LOAD),
    .dec_i      (to_dec),
    .zero_o     (to_zero)
  );

  assign timeout_hit = (state_q == ACCESS) && !bus_ready && to_zero;

  // Remember whether the access that just ended was an abort, so bus_err
  // can be decoded alongside mem_res in HOLD.
  always_comb begin
    err_d = err_q;
    if (access_done) begin
      err_d = timeout_hit;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus_err = (state_q == HOLD) && err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Request latch and read data register
  // -------------------------------------------------------------------------
  always_comb begin
    req_d = req_q;
    if (accept) begin
      req_d = '{addr: BUS_ADDR_W'(req_addr), we: req_we, wdata: req_wdata};
    end
  end

  // Read data is captured only on the edge that leaves ACCESS, never while
  // the device is still inserting wait states.
  always_comb begin
    rd_data_d = rd_data_q;
    if (access_done && !req_q.we) begin
      rd_data_d = timeout_hit ? BUS_ERR_DATA : bus_rdata;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      req_q     <= '0;
      rd_data_q <= 8'h00;
    end else begin
      req_q     <= req_d;
      rd_data_q <= rd_data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs, decoded from registers only
  // -------------------------------------------------------------------------
  // CS, address, write data and its enable are held from SETUP through
  // HOLD; the strobes are confined to ACCESS so they open and close inside
  // the chip-select window. A read never enables the write-data driver, and
  // oe/we depend on the latched direction so they can never overlap.
  assign req_ready    = (state_q == IDLE);
  assign mem_res      = (state_q == HOLD);
  assign rd_data      = rd_data_q;
  assign bus_addr     = ADDR_W'(req_q.addr);
  assign bus_wdata    = req_q.wdata;
  assign bus_cs_n     = (state_q == IDLE);
  assign bus_oe_n     = !((state_q == ACCESS) && !req_q.we);
  assign bus_we_n     = !((state_q == ACCESS) && req_q.we);
  assign bus_wdata_en = (state_q != IDLE) && req_q.we;

endmodule : mem_bus_ctrl

// File: tb/tb_mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_ctrl
// Self-checking bench for mem_bus_ctrl (WAIT_CYCLES=2, TIMEOUT_CYCLES=8).
// Each transaction pushes its expected completion (cycle, rd_data, bus_err)
// onto a scoreboard; a monitor pops and compares when mem_res is seen.
// The timeout scenario runs only when MEM_BUS_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_mem_bus_ctrl;

  localparam int WAIT = 2;
  localparam int TO   = 8;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic        mem_res;
  logic [7:0]  rd_data;
  logic        bus_err;
  logic [15:0] bus_addr;
  logic        bus_cs_n;
  logic        bus_oe_n;
  logic        bus_we_n;
  logic [7:0]  bus_wdata;
  logic        bus_wdata_en;
  logic [7:0]  bus_rdata;
  logic        bus_ready;

  mem_bus_ctrl #(
    .ADDR_W         (16),
    .WAIT_CYCLES    (WAIT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst      (cpu_rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .mem_res      (mem_res),
    .rd_data      (rd_data),
    .bus_err      (bus_err),
    .bus_addr     (bus_addr),
    .bus_cs_n     (bus_cs_n),
    .bus_oe_n     (bus_oe_n),
    .bus_we_n     (bus_we_n),
    .bus_wdata    (bus_wdata),
    .bus_wdata_en (bus_wdata_en),
    .bus_rdata    (bus_rdata),
    .bus_ready    (bus_ready)
  );

  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    logic [7:0] rd;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Fields presented while a back-to-back request is held valid.
  logic        nxt_we;
  logic [15:0] nxt_addr;
  logic [7:0]  nxt_wd;

  // Completion monitor and always-on bus invariants.
  always @(negedge cpu_clk) begin
    if (cpu_rst === 1'b0) begin
      total++;
      if (bus_oe_n === 1'b0 && bus_we_n === 1'b0) begin
        bad++;
        $display("FAIL oe_we_overlap cyc=%0d got oe_n=%b we_n=%b exp not both 0", cyc, bus_oe_n, bus_we_n);
      end
      total++;
      if (bus_oe_n === 1'b0 && bus_wdata_en !== 1'b0) begin
        bad++;
        $display("FAIL wdata_en_on_read cyc=%0d got wdata_en=%b exp 0", cyc, bus_wdata_en);
      end
      if (mem_res === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_mem_res cyc=%0d got mem_res=1 exp no completion pending", cyc);
        end else begin
          e = sb.pop_front();
          total++;
          if (cyc !== e.cyc) begin
            bad++;
            $display("FAIL mem_res_cycle got=%0d exp=%0d", cyc, e.cyc);
          end
          total++;
          if (rd_data !== e.rd) begin
            bad++;
            $display("FAIL rd_data got=%h exp=%h", rd_data, e.rd);
          end
          total++;
          if (bus_err !== e.err) begin
            bad++;
            $display("FAIL bus_err got=%b exp=%b", bus_err, e.err);
          end
          $display("txn done cyc=%0d rd_data=%h bus_err=%b", cyc, rd_data, bus_err);
        end
      end
    end
  end

  // Runs one request to completion. low = number of ACCESS cycles with
  // bus_ready low from the start of ACCESS (-1 = stuck low).
  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         input logic [7:0] rd, input int low, input logic [7:0] exp_rd,
                         input logic exp_err, input logic keep_valid,
                         output int acc_cyc, output int hold_cyc);
    int n = 0, guard = 0, acc_len = 0, t_exp = 0, c = 0;
    int cs_cnt = 0, oe_cnt = 0, we_cnt = 0, en_cnt = 0;
    int early = 0, busy_bad = 0, addr_bad = 0, wd_bad = 0;
    logic [7:0] rd_before;
    logic done = 1'b0;
    acc_cyc  = 0;
    hold_cyc = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge cpu_clk);
      guard++;
    end
    if (req_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout got req_ready=%b exp 1 within 20 cycles", req_ready);
      req_valid = 1'b0;
      return;
    end
    n = cyc;
    acc_cyc = n;
    if (low < 0) acc_len = TO;
    else acc_len = (low + 1 > WAIT + 1) ? low + 1 : WAIT + 1;
    t_exp = n + 2 + acc_len;
    sb.push_back('{t_exp, exp_rd, exp_err});
    rd_before = rd_data;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge cpu_clk);
      c = cyc;
      if (k == 1) begin
        if (keep_valid) begin
          req_we = nxt_we; req_addr = nxt_addr; req_wdata = nxt_wd;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (c >= n + 2 && (low < 0 || c < n + 2 + low)) begin
        bus_ready = 1'b0;
        bus_rdata = 8'($urandom);
      end else begin
        bus_ready = 1'b1;
        bus_rdata = rd;
      end
      if (bus_cs_n === 1'b0) cs_cnt++;
      if (bus_oe_n === 1'b0) oe_cnt++;
      if (bus_we_n === 1'b0) we_cnt++;
      if (bus_wdata_en === 1'b1) begin
        en_cnt++;
        if (bus_wdata !== wd) wd_bad++;
      end
      if (bus_cs_n === 1'b0 && bus_addr !== addr) addr_bad++;
      if (req_ready !== 1'b0) busy_bad++;
      if (mem_res === 1'b1) begin
        done = 1'b1;
        hold_cyc = c;
      end else if (rd_data !== rd_before) begin
        early++;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL no_mem_res got none exp mem_res at cyc %0d", t_exp);
    end
    total++;
    if (cs_cnt !== acc_len + 2) begin
      bad++; $display("FAIL cs_cycles got=%0d exp=%0d", cs_cnt, acc_len + 2);
    end
    total++;
    if (oe_cnt !== (we ? 0 : acc_len)) begin
      bad++; $display("FAIL oe_cycles got=%0d exp=%0d", oe_cnt, we ? 0 : acc_len);
    end
    total++;
    if (we_cnt !== (we ? acc_len : 0)) begin
      bad++; $display("FAIL we_cycles got=%0d exp=%0d", we_cnt, we ? acc_len : 0);
    end
    total++;
    if (en_cnt !== (we ? acc_len + 2 : 0)) begin
      bad++; $display("FAIL wdata_en_cycles got=%0d exp=%0d", en_cnt, we ? acc_len + 2 : 0);
    end
    total++;
    if (wd_bad !== 0 || addr_bad !== 0) begin
      bad++; $display("FAIL bus_addr_wdata got bad addr=%0d wdata=%0d cycles exp 0", addr_bad, wd_bad);
    end
    total++;
    if (busy_bad !== 0) begin
      bad++; $display("FAIL req_ready_busy got %0d cycles high exp 0", busy_bad);
    end
    total++;
    if (early !== 0) begin
      bad++; $display("FAIL rd_data_early got %0d changes before HOLD exp 0", early);
    end
    $display("txn we=%b addr=%h wdata=%h accepted cyc=%0d hold cyc=%0d", we, addr, wd, n, hold_cyc);
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    repeat (3) @(negedge cpu_clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    total++; if (mem_res !== 1'b0) begin bad++; $display("FAIL rst_mem_res got=%b exp=0", mem_res); end
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL rst_bus_err got=%b exp=0", bus_err); end
    total++; if (bus_wdata_en !== 1'b0) begin bad++; $display("FAIL rst_wdata_en got=%b exp=0", bus_wdata_en); end
    total++; if (bus_cs_n !== 1'b1) begin bad++; $display("FAIL rst_cs_n got=%b exp=1", bus_cs_n); end
    total++; if (bus_oe_n !== 1'b1) begin bad++; $display("FAIL rst_oe_n got=%b exp=1", bus_oe_n); end
    total++; if (bus_we_n !== 1'b1) begin bad++; $display("FAIL rst_we_n got=%b exp=1", bus_we_n); end
    total++; if (bus_addr !== 16'h0000) begin bad++; $display("FAIL rst_bus_addr got=%h exp=0000", bus_addr); end
    total++; if (bus_wdata !== 8'h00) begin bad++; $display("FAIL rst_bus_wdata got=%h exp=00", bus_wdata); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd_data got=%h exp=00", rd_data); end
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    $display("reset checked cyc=%0d", cyc);
  endtask

  task automatic test_read();
    int a, h;
    run_txn(1'b0, 16'h1234, 8'h00, 8'hA5, 0, 8'hA5, 1'b0, 1'b0, a, h);
  endtask

  task automatic test_write();
    int a, h;
    run_txn(1'b1, 16'h8001, 8'h3C, 8'h99, 0, 8'hA5, 1'b0, 1'b0, a, h);
  endtask

  task automatic test_wait_states();
    int a, h;
    run_txn(1'b0, 16'h0F0F, 8'h00, 8'h5A, 6, 8'h5A, 1'b0, 1'b0, a, h);
  endtask

  task automatic test_back_to_back();
    int a1, h1, a2, h2;
    nxt_we = 1'b0; nxt_addr = 16'h0020; nxt_wd = 8'h00;
    run_txn(1'b1, 16'h0010, 8'h77, 8'h11, 0, 8'h5A, 1'b0, 1'b1, a1, h1);
    run_txn(1'b0, 16'h0020, 8'h00, 8'hC3, 0, 8'hC3, 1'b0, 1'b0, a2, h2);
    total++;
    if (a2 !== h1 + 1) begin
      bad++; $display("FAIL b2b_accept_cycle got=%0d exp=%0d", a2, h1 + 1);
    end
  endtask

  task automatic test_reset_mid_access();
    int guard = 0;
    int res_seen = 0;
    bus_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4444; req_wdata = 8'h00;
    while (req_ready !== 1'b1 && guard < 20) begin @(negedge cpu_clk); guard++; end
    @(negedge cpu_clk);
    req_valid = 1'b0;
    guard = 0;
    while (bus_oe_n !== 1'b0 && guard < 10) begin @(negedge cpu_clk); guard++; end
    total++;
    if (bus_oe_n !== 1'b0) begin
      bad++; $display("FAIL mid_rst_reach_access got oe_n=%b exp=0", bus_oe_n);
    end
    cpu_rst = 1'b1;
    @(negedge cpu_clk);
    total++;
    if ({bus_cs_n, bus_oe_n, bus_we_n} !== 3'b111) begin
      bad++; $display("FAIL mid_rst_strobes got=%b exp=111", {bus_cs_n, bus_oe_n, bus_we_n});
    end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_req_ready got=%b exp=1", req_ready); end
    total++; if (mem_res !== 1'b0) begin bad++; $display("FAIL mid_rst_mem_res got=%b exp=0", mem_res); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL mid_rst_rd_data got=%h exp=00", rd_data); end
    total++; if (bus_wdata_en !== 1'b0) begin bad++; $display("FAIL mid_rst_wdata_en got=%b exp=0", bus_wdata_en); end
    cpu_rst = 1'b0;
    bus_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge cpu_clk);
      if (mem_res !== 1'b0) res_seen++;
    end
    total++;
    if (res_seen !== 0) begin
      bad++; $display("FAIL mid_rst_dropped got %0d mem_res cycles exp 0", res_seen);
    end
    $display("reset during ACCESS checked cyc=%0d", cyc);
  endtask

`ifdef MEM_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int a, h;
    run_txn(1'b0, 16'h2468, 8'h00, 8'h42, -1, 8'hFF, 1'b1, 1'b0, a, h);
    bus_ready = 1'b1;
  endtask
`endif

  initial begin
    cpu_rst   = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 8'h00;
    bus_rdata = 8'h00;
    bus_ready = 1'b1;
    nxt_we    = 1'b0;
    nxt_addr  = 16'h0000;
    nxt_wd    = 8'h00;
    test_reset();
    test_read();
    test_write();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_BUS_TIMEOUT_EN
    test_timeout();
`endif
    repeat (4) @(negedge cpu_clk);
    total++;
    if (sb.size() !== 0) begin
      bad++; $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no finish by cyc=%0d exp finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_bus_ctrl
